// File: rtl/wqe_dispatch_pkg.sv
// Shared definitions for the work-queue dispatcher: WQE layout, descriptor
// register map, control-word layout and FSM state encoding.
package wqe_dispatch_pkg;

  // Work-queue head entry, MSB first. dataLen[0] is the most significant length.
  typedef struct packed {
    logic [4:0]      opcode;
    logic [2:0]      dataNum;
    logic [7:0]      tid;
    logic [0:3][8:0] dataLen;
    logic [63:0]     descAddr;
  } wqe_t;

  localparam int WQE_W = $bits(wqe_t);

  localparam logic [2:0] MAX_SEGMENTS = 3'd4;

  // Descriptor register offsets within the DMA controller window.
  localparam logic [7:0] REG_ADDR_LO = 8'h00;
  localparam logic [7:0] REG_ADDR_HI = 8'h04;
  localparam logic [7:0] REG_CTL     = 8'h08;

  // Control word written to REG_CTL, MSB first.
  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] tid;
    logic       last;
    logic [1:0] segIdx;
    logic [6:0] rsvd;
    logic [8:0] len;
  } ctlWord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    WR_CTL = 3'd3,
    NEXT   = 3'd4
  } dispState_t;

endpackage

// File: rtl/wqe_credit_counter.sv
// Tracks descriptors the DMA engine can still accept: issue consumes a
// credit, done returns one, both together cancel, and the count saturates.
module wqe_credit_counter #(
  parameter int  MAX_CREDIT = 8,
  localparam int CNT_W      = $clog2(MAX_CREDIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CREDIT);

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (issue && !done) begin
      if (count != '0) count <= count - 1'b1;
    end else if (done && !issue) begin
      if (count < FULL) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wqe_dispatch.sv
// Pops WQEs from a show-ahead FIFO and writes one LO/HI/CTL descriptor
// triplet per segment to the DMA controller, gated by outstanding credit.
module wqe_dispatch
  import wqe_dispatch_pkg::*;
#(
  parameter logic [7:0] DESC_BASE  = 8'h00,
  parameter int         MAX_CREDIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WQE_W-1:0] wqeData,
  input  logic             wqeEmpty,
  output logic             wqePop,
  output logic             dscChipSelect,
  output logic             dscWrite,
  output logic [7:0]       dscAddress,
  output logic [31:0]      dscWriteData,
  output logic [3:0]       dscByteEnable,
  input  logic             dscWaitRequest,
  input  logic             dmaDone,
  output logic             busy,
  output logic [7:0]       errCount
);

  localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);

  dispState_t          state, stateNext;
  wqe_t                head;
  logic                headValid;
  logic                armed;
  logic [4:0]          opcode;
  logic [2:0]          dataNum;
  logic [7:0]          tid;
  logic [0:3][8:0]     dataLen;
  logic [63:0]         segAddr;
  logic [1:0]          segIdx;
  logic [8:0]          curLen;
  logic                lastSeg;
  ctlWord_t            ctlWord;
  logic                creditIssue;
  logic [CREDIT_W-1:0] credit;

  assign head      = wqe_t'(wqeData);
  assign headValid = (head.dataNum != 3'd0) && (head.dataNum <= MAX_SEGMENTS);
  assign curLen    = dataLen[segIdx];
  assign lastSeg   = ({1'b0, segIdx} == (dataNum - 3'd1));

  always_comb begin
    ctlWord        = '0;
    ctlWord.opcode = opcode;
    ctlWord.tid    = tid;
    ctlWord.last   = lastSeg;
    ctlWord.segIdx = segIdx;
    ctlWord.len    = curLen;
  end

  wqe_credit_counter #(
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clock (clock),
    .reset (reset),
    .issue (creditIssue),
    .done  (dmaDone),
    .count (credit)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    stateNext     = state;
    wqePop        = 1'b0;
    dscChipSelect = 1'b0;
    dscAddress    = '0;
    dscWriteData  = '0;
    creditIssue   = 1'b0;
    unique case (state)
      IDLE: begin
        // armed keeps the pop strobe quiet until the first edge after reset.
        if (armed && !wqeEmpty) begin
          wqePop    = 1'b1;
          stateNext = headValid ? WR_LO : IDLE;
        end
      end
      WR_LO: begin
        if (credit != '0) begin
          dscChipSelect = 1'b1;
          dscAddress    = DESC_BASE + REG_ADDR_LO;
          dscWriteData  = segAddr[31:0];
          if (!dscWaitRequest) stateNext = WR_HI;
        end
      end
      WR_HI: begin
        dscChipSelect = 1'b1;
        dscAddress    = DESC_BASE + REG_ADDR_HI;
        dscWriteData  = segAddr[63:32];
        if (!dscWaitRequest) stateNext = WR_CTL;
      end
      WR_CTL: begin
        dscChipSelect = 1'b1;
        dscAddress    = DESC_BASE + REG_CTL;
        dscWriteData  = ctlWord;
        if (!dscWaitRequest) begin
          creditIssue = 1'b1;
          stateNext   = NEXT;
        end
      end
      NEXT: begin
        stateNext = lastSeg ? IDLE : WR_LO;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: the segment-length array is reset like every other register so an
  // abandoned WQE leaves no stale context behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      opcode   <= '0;
      dataNum  <= '0;
      tid      <= '0;
      dataLen  <= '0;
      segAddr  <= '0;
      segIdx   <= '0;
      errCount <= '0;
    end else begin
      state <= stateNext;
      armed <= 1'b1;
      if (wqePop) begin
        opcode  <= head.opcode;
        dataNum <= head.dataNum;
        tid     <= head.tid;
        dataLen <= head.dataLen;
        segAddr <= head.descAddr;
        segIdx  <= '0;
        if (!headValid && errCount != 8'hff) errCount <= errCount + 1'b1;
      end
      if (state == NEXT) begin
        segAddr <= segAddr + {53'd0, curLen, 2'b00};
        segIdx  <= segIdx + 1'b1;
      end
    end
  end

  assign dscWrite      = dscChipSelect;
  assign dscByteEnable = 4'hf;
  assign busy          = (state != IDLE);

endmodule
